// File: rtl/cache_mem_ctrl.sv
// ============================================================================
//  Module   : cache_mem_ctrl
//  Purpose  : Refill controller with a write-back FIFO that shares one memory
//             port. Optional macro CACHE_MEM_CTRL_WB_FORWARD_EN answers
//             matching misses straight from the write-back buffer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_mem_ctrl #(
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_miss,
  input  logic [31:0] i_miss_addr,
  input  logic        i_evict,
  input  logic [31:0] i_evict_addr,
  input  logic [31:0] i_evict_data,
  output logic [31:0] o_memory_line,
  output logic        o_memory_response,
  output logic        o_wb_full,
  output logic        o_wb_overflow,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int c_aw = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
`ifdef CACHE_MEM_CTRL_WB_FORWARD_EN
  localparam bit c_fwd_en = 1'b1;
`else
  localparam bit c_fwd_en = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_WR   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  state_t r_state, w_state_next;

  logic [31:0]     r_wb_addr [WB_DEPTH];
  logic [31:0]     r_wb_data [WB_DEPTH];
  logic [c_aw-1:0] r_head, r_tail;
  logic [c_aw:0]   r_count;
  logic            r_overflow, r_holdoff;
  logic [25:0]     r_miss_line;
  logic [31:0]     r_memory_line;

  logic        w_full, w_empty, w_push, w_pop, w_wr_state, w_miss_take;
  logic        w_match;
  logic [31:0] w_fwd_data;
  logic        w_unused_offset;

  assign w_full      = (r_count == (c_aw+1)'(WB_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = i_evict && !w_full;
  assign w_wr_state  = (r_state == WB_WR) || ((r_state == DRAIN) && !w_empty);
  assign w_pop       = w_wr_state && i_mem_ready;
  assign w_miss_take = (r_state == IDLE) && cache_miss && !r_holdoff;
  // Refills are line-granular, so the miss offset never reaches the bus.
  assign w_unused_offset = &{1'b0, i_miss_addr[5:0]};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_tail] <= i_evict_addr;
      r_wb_data[r_tail] <= i_evict_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A full buffer drops the eviction even if a pop frees a slot this cycle.
      if (i_evict && w_full) r_overflow <= 1'b1;
    end
  end

  // Scan oldest to newest so the newest match wins; a same-cycle push is newest.
  always_comb begin
    w_match    = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (((c_aw+1)'(i) < r_count) &&
          (r_wb_addr[r_head + c_aw'(i)][31:6] == i_miss_addr[31:6])) begin
        w_match    = 1'b1;
        w_fwd_data = r_wb_data[r_head + c_aw'(i)];
      end
    end
    if (w_push && (i_evict_addr[31:6] == i_miss_addr[31:6])) begin
      w_match    = 1'b1;
      w_fwd_data = i_evict_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_holdoff     <= 1'b0;
      r_miss_line   <= '0;
      r_memory_line <= '0;
    end else begin
      r_state   <= w_state_next;
      r_holdoff <= (r_state == RESP);
      if (w_miss_take) r_miss_line <= i_miss_addr[31:6];
      if ((r_state == RD_WAIT) && i_mem_rvalid)
        r_memory_line <= i_mem_rdata;
      else if (c_fwd_en && w_miss_take && w_match)
        r_memory_line <= w_fwd_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_miss_take) begin
          if (w_match) w_state_next = c_fwd_en ? RESP : DRAIN;
          else         w_state_next = RD_REQ;
        end else if (!w_empty) begin
          w_state_next = WB_WR;
        end
      end
      WB_WR:   if (i_mem_ready)  w_state_next = IDLE;
      RD_REQ:  if (i_mem_ready)  w_state_next = RD_WAIT;
      RD_WAIT: if (i_mem_rvalid) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      DRAIN:   if (w_empty)      w_state_next = RD_REQ;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_wr_state) begin
      o_mem_req   = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = r_wb_addr[r_head];
      o_mem_wdata = r_wb_data[r_head];
    end else if (r_state == RD_REQ) begin
      o_mem_req  = 1'b1;
      o_mem_addr = {r_miss_line, 6'b0};
    end
  end

  assign o_memory_line     = r_memory_line;
  assign o_memory_response = (r_state == RESP);
  assign o_wb_full         = w_full;
  assign o_wb_overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: table-driven refills plus hand-written
// buffer, ordering, forwarding and reset sequences.
`default_nettype none

module tb_cache_mem_ctrl;

  logic        clk, rst;
  logic        cache_miss, i_evict, i_mem_ready, i_mem_rvalid;
  logic [31:0] i_miss_addr, i_evict_addr, i_evict_data, i_mem_rdata;
  logic [31:0] o_memory_line, o_mem_addr, o_mem_wdata;
  logic        o_memory_response, o_wb_full, o_wb_overflow, o_mem_req, o_mem_we;

  cache_mem_ctrl #(.WB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cache_miss(cache_miss), .i_miss_addr(i_miss_addr),
    .i_evict(i_evict), .i_evict_addr(i_evict_addr), .i_evict_data(i_evict_data),
    .o_memory_line(o_memory_line), .o_memory_response(o_memory_response),
    .o_wb_full(o_wb_full), .o_wb_overflow(o_wb_overflow), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] rdata; logic [31:0] exp_addr; } vec_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } req_t;

  vec_t        vecs[4];
  req_t        log_q[$];
  logic [31:0] rd_data;
  int          n_cmp = 0, n_fail = 0;
  int          rd_cnt = 0;

  // Memory model: logs accepted requests, returns read data 3 cycles after acceptance.
  initial begin
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (o_mem_req && i_mem_ready) begin
        log_q.push_back('{o_mem_we, o_mem_addr, o_mem_wdata});
        if (!o_mem_we) rd_cnt = 3;
      end
      @(posedge clk); #1;
      i_mem_rvalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = rd_data;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input string name, input int budget, input logic [31:0] exp_line);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_memory_response) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_resp_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, "_line"}, o_memory_line, exp_line);
      @(negedge clk);
      chk({name, "_resp_one_cycle"}, 32'(o_memory_response), 32'd0);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic we,
                         input logic [31:0] addr, input logic [31:0] data, input bit cmp_data);
    if (idx < log_q.size()) begin
      chk({name, "_we"}, 32'(log_q[idx].we), 32'(we));
      chk({name, "_addr"}, log_q[idx].addr, addr);
      if (cmp_data) chk({name, "_data"}, log_q[idx].data, data);
    end else begin
      chk({name, "_present"}, 32'd0, 32'd1);
    end
  endtask

  task automatic do_reset();
    cyc(); rst = 1'b1;
    cyc(); cyc(); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mark;
    logic [31:0] e_addr[5];
    logic [31:0] e_data[5];
    bit got_resp;

    vecs[0] = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_1200};
    vecs[1] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFC0};
    vecs[2] = '{32'h0000_003F, 32'hA5A5_5A5A, 32'h0000_0000};
    vecs[3] = '{32'h8000_0040, 32'h0000_0001, 32'h8000_0040};

    rst = 1'b1; cache_miss = 1'b0; i_miss_addr = '0; i_evict = 1'b0;
    i_evict_addr = '0; i_evict_data = '0; i_mem_ready = 1'b0; rd_data = '0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_line", o_memory_line, 32'h0);
    chk("rst_resp", 32'(o_memory_response), 32'd0);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_addr", o_mem_addr, 32'h0);
    chk("rst_wdata", o_mem_wdata, 32'h0);
    chk("rst_full", 32'(o_wb_full), 32'd0);
    chk("rst_ovf", 32'(o_wb_overflow), 32'd0);

    // Plain refills from the vector table.
    cyc(); i_mem_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      cyc(); cache_miss = 1'b1; i_miss_addr = vecs[v].addr; rd_data = vecs[v].rdata;
      cyc(); cache_miss = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_rd_req", v), 32'(o_mem_req), 32'd1);
      chk($sformatf("v%0d_rd_we", v), 32'(o_mem_we), 32'd0);
      chk($sformatf("v%0d_rd_addr", v), o_mem_addr, vecs[v].exp_addr);
      wait_resp($sformatf("v%0d", v), 12, vecs[v].rdata);
      repeat (2) cyc();
    end

    // Fill the buffer with memory stalled, overflow on the fifth eviction.
    cyc(); i_mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e_addr[k] = 32'h0001_0000 + 32'(k * 64);
      e_data[k] = 32'hD000_0000 + 32'(k);
      cyc(); i_evict = 1'b1; i_evict_addr = e_addr[k]; i_evict_data = e_data[k];
      @(negedge clk);
      if (k == 4) begin
        chk("fill_full_after4", 32'(o_wb_full), 32'd1);
        chk("fill_no_ovf_yet", 32'(o_wb_overflow), 32'd0);
      end
    end
    cyc(); i_evict = 1'b0;
    @(negedge clk);
    chk("fill_ovf", 32'(o_wb_overflow), 32'd1);
    chk("fill_full_hold", 32'(o_wb_full), 32'd1);
    chk("stall_req", 32'(o_mem_req), 32'd1);
    chk("stall_we", 32'(o_mem_we), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("stall%0d_addr", k), o_mem_addr, e_addr[0]);
      chk($sformatf("stall%0d_wdata", k), o_mem_wdata, e_data[0]);
    end
    mark = log_q.size();
    cyc(); i_mem_ready = 1'b1;
    repeat (20) cyc();
    @(negedge clk);
    chk("drain_write_count", 32'(log_q.size() - mark), 32'd4);
    for (int k = 0; k < 4; k++)
      chk_log($sformatf("drain_w%0d", k), mark + k, 1'b1, e_addr[k], e_data[k], 1'b1);
    chk("drain_full_clear", 32'(o_wb_full), 32'd0);
    chk("drain_ovf_sticky", 32'(o_wb_overflow), 32'd1);
    do_reset();
    @(negedge clk);
    chk("rst2_ovf", 32'(o_wb_overflow), 32'd0);
    chk("rst2_full", 32'(o_wb_full), 32'd0);

    // Miss hitting an eviction pushed in the same cycle.
    mark = log_q.size();
    cyc(); i_evict = 1'b1; i_evict_addr = 32'h0000_4000; i_evict_data = 32'h1111_2222;
    cache_miss = 1'b1; i_miss_addr = 32'h0000_4000; rd_data = 32'hCAFE_F00D;
    cyc(); i_evict = 1'b0; cache_miss = 1'b0;
`ifdef CACHE_MEM_CTRL_WB_FORWARD_EN
    @(negedge clk);
    chk("fwd_resp", 32'(o_memory_response), 32'd1);
    chk("fwd_line", o_memory_line, 32'h1111_2222);
    chk("fwd_no_req", 32'(o_mem_req), 32'd0);
    repeat (15) cyc();
    chk("fwd_req_count", 32'(log_q.size() - mark), 32'd1);
    chk_log("fwd_wb", mark, 1'b1, 32'h0000_4000, 32'h1111_2222, 1'b1);
`else
    wait_resp("match", 20, 32'hCAFE_F00D);
    repeat (4) cyc();
    chk("match_req_count", 32'(log_q.size() - mark), 32'd2);
    chk_log("match_wb_first", mark, 1'b1, 32'h0000_4000, 32'h1111_2222, 1'b1);
    chk_log("match_rd_second", mark + 1, 1'b0, 32'h0000_4000, 32'h0, 1'b0);
`endif
    repeat (4) cyc();

    // Miss and eviction together while one entry is already pending.
    mark = log_q.size();
    cyc(); i_evict = 1'b1; i_evict_addr = 32'h0003_0000; i_evict_data = 32'hE0E0_0000;
    cyc(); i_evict = 1'b0;
    cyc(); i_evict = 1'b1; i_evict_addr = 32'h0003_0040; i_evict_data = 32'hAAAA_0001;
    cyc(); i_evict_addr = 32'h0003_0080; i_evict_data = 32'hBBBB_0002;
    cache_miss = 1'b1; i_miss_addr = 32'h0005_0010; rd_data = 32'h5555_AAAA;
    cyc(); i_evict = 1'b0; cache_miss = 1'b0;
    wait_resp("prio", 20, 32'h5555_AAAA);
    repeat (10) cyc();
    chk("prio_req_count", 32'(log_q.size() - mark), 32'd4);
    chk_log("prio_w_e0", mark, 1'b1, 32'h0003_0000, 32'hE0E0_0000, 1'b1);
    chk_log("prio_rd", mark + 1, 1'b0, 32'h0005_0000, 32'h0, 1'b0);
    chk_log("prio_w_a", mark + 2, 1'b1, 32'h0003_0040, 32'hAAAA_0001, 1'b1);
    chk_log("prio_w_b", mark + 3, 1'b1, 32'h0003_0080, 32'hBBBB_0002, 1'b1);

    // Reset while the read is outstanding; the late rvalid must be ignored.
    cyc(); cache_miss = 1'b1; i_miss_addr = 32'h0000_7000; rd_data = 32'h7777_7777;
    cyc(); cache_miss = 1'b0;
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    got_resp = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_memory_response) got_resp = 1'b1;
    end
    chk("rstrd_no_resp", 32'(got_resp), 32'd0);
    chk("rstrd_line", o_memory_line, 32'h0);
    chk("rstrd_req", 32'(o_mem_req), 32'd0);
    chk("rstrd_we", 32'(o_mem_we), 32'd0);
    chk("rstrd_addr", o_mem_addr, 32'h0);
    chk("rstrd_wdata", o_mem_wdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
